// File: rtl/plic_target.sv
// plic_target: per-target claim/complete stage of the PLIC.
//
// This block sits after the priority tree. It registers the winning priority
// and ID, and it compares the priority with the target threshold to drive
// irq_o. It also runs the claim/complete handshake and sends one-cycle clear
// and complete pulses to the source gateways.
//
// Optional feature: define PLIC_TARGET_IRQ_REG_EN to register irq_o.
// A flop then adds one cycle of latency from prio_i/idx_i/thold_i.
module plic_target #(
    parameter int PRIO_WIDTH = 3,
    parameter int IRQ_WIDTH  = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [PRIO_WIDTH-1:0] prio_i,
    input  logic [IRQ_WIDTH-1:0]  idx_i,
    input  logic [PRIO_WIDTH-1:0] thold_i,
    input  logic                  claim_i,
    input  logic                  complete_i,
    input  logic [IRQ_WIDTH-1:0]  complete_id_i,
    output logic                  irq_o,
    output logic [IRQ_WIDTH-1:0]  claim_id_o,
    output logic                  clr_vld_o,
    output logic [IRQ_WIDTH-1:0]  clr_idx_o,
    output logic                  cmpl_vld_o,
    output logic [IRQ_WIDTH-1:0]  cmpl_idx_o,
    output logic                  busy_o
);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_CLAIMED = 1'b1
    } state_t;

    logic [PRIO_WIDTH-1:0] s_prio_reg;
    logic [IRQ_WIDTH-1:0]  s_idx_reg;
    logic                  req;

    state_t                state_reg,     state_next;
    logic [IRQ_WIDTH-1:0]  claim_id_reg,  claim_id_next;
    // This register holds the ID that was actually granted. claim_id_reg can
    // be overwritten with 0 when a second claim arrives while CLAIMED. The
    // matching complete must still be compared against the granted ID.
    logic [IRQ_WIDTH-1:0]  active_id_reg, active_id_next;
    logic                  clr_vld_reg,   clr_vld_next;
    logic [IRQ_WIDTH-1:0]  clr_idx_reg,   clr_idx_next;
    logic                  cmpl_vld_reg,  cmpl_vld_next;
    logic [IRQ_WIDTH-1:0]  cmpl_idx_reg,  cmpl_idx_next;

    // Stage register: capture the priority tree winner every cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s_prio_reg <= '0;
            s_idx_reg  <= '0;
        end else begin
            s_prio_reg <= prio_i;
            s_idx_reg  <= idx_i;
        end
    end

    // ID 0 is "no interrupt". The threshold compare is strict and unsigned,
    // so priority 0 can never raise a request.
    assign req = (s_idx_reg != '0) && (s_prio_reg > thold_i);

    // Handshake decode: next state, claim data, and gateway pulses.
    always_comb begin
        state_next     = state_reg;
        claim_id_next  = claim_id_reg;
        active_id_next = active_id_reg;
        clr_vld_next   = 1'b0;
        clr_idx_next   = clr_idx_reg;
        cmpl_vld_next  = 1'b0;
        cmpl_idx_next  = cmpl_idx_reg;
        case (state_reg)
            ST_IDLE: begin
                // A complete while IDLE is ignored, even if it arrives
                // together with a claim.
                if (claim_i) begin
                    if (req) begin
                        claim_id_next  = s_idx_reg;
                        active_id_next = s_idx_reg;
                        clr_vld_next   = 1'b1;
                        clr_idx_next   = s_idx_reg;
                        state_next     = ST_CLAIMED;
                    end else begin
                        claim_id_next = '0;
                    end
                end
            end
            ST_CLAIMED: begin
                // Only one claim can be outstanding, so any further claim
                // reads back 0.
                if (claim_i) begin
                    claim_id_next = '0;
                end
                if (complete_i && (complete_id_i == active_id_reg)) begin
                    cmpl_vld_next = 1'b1;
                    cmpl_idx_next = complete_id_i;
                    state_next    = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Handshake state and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= ST_IDLE;
            claim_id_reg  <= '0;
            active_id_reg <= '0;
            clr_vld_reg   <= 1'b0;
            clr_idx_reg   <= '0;
            cmpl_vld_reg  <= 1'b0;
            cmpl_idx_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            claim_id_reg  <= claim_id_next;
            active_id_reg <= active_id_next;
            clr_vld_reg   <= clr_vld_next;
            clr_idx_reg   <= clr_idx_next;
            cmpl_vld_reg  <= cmpl_vld_next;
            cmpl_idx_reg  <= cmpl_idx_next;
        end
    end

`ifdef PLIC_TARGET_IRQ_REG_EN
    logic irq_reg;

    // Registered interrupt line. It is cleared on the claim edge, so it is
    // low in the same cycle as the combinational version.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= req && !claim_i && (state_next == ST_IDLE);
        end
    end

    assign irq_o = irq_reg;
`else
    assign irq_o = req && (state_reg == ST_IDLE);
`endif

    assign claim_id_o = claim_id_reg;
    assign clr_vld_o  = clr_vld_reg;
    assign clr_idx_o  = clr_idx_reg;
    assign cmpl_vld_o = cmpl_vld_reg;
    assign cmpl_idx_o = cmpl_idx_reg;
    assign busy_o     = (state_reg == ST_CLAIMED);

endmodule

// File: tb/tb_plic_target.sv
// tb_plic_target: scoreboard bench for plic_target.
//
// The driver applies one cycle of stimulus and pushes the outputs expected
// for that cycle. The expected values come from a behavioural model that
// tracks which ID the target currently owns. A separate monitor pops and
// compares the expected values on each falling edge.
module tb_plic_target;

    localparam int PW = 3;
    localparam int IW = 5;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [PW-1:0] prio_i = '0;
    logic [IW-1:0] idx_i = '0;
    logic [PW-1:0] thold_i = '0;
    logic          claim_i = 1'b0;
    logic          complete_i = 1'b0;
    logic [IW-1:0] complete_id_i = '0;
    logic          irq_o;
    logic [IW-1:0] claim_id_o;
    logic          clr_vld_o;
    logic [IW-1:0] clr_idx_o;
    logic          cmpl_vld_o;
    logic [IW-1:0] cmpl_idx_o;
    logic          busy_o;

    always #5 clk_i = ~clk_i;

    plic_target #(.PRIO_WIDTH(PW), .IRQ_WIDTH(IW)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .prio_i        (prio_i),
        .idx_i         (idx_i),
        .thold_i       (thold_i),
        .claim_i       (claim_i),
        .complete_i    (complete_i),
        .complete_id_i (complete_id_i),
        .irq_o         (irq_o),
        .claim_id_o    (claim_id_o),
        .clr_vld_o     (clr_vld_o),
        .clr_idx_o     (clr_idx_o),
        .cmpl_vld_o    (cmpl_vld_o),
        .cmpl_idx_o    (cmpl_idx_o),
        .busy_o        (busy_o)
    );

    typedef struct {
        logic          irq;
        logic [IW-1:0] claim_id;
        logic          clr_vld;
        logic [IW-1:0] clr_idx;
        logic          cmpl_vld;
        logic [IW-1:0] cmpl_idx;
        logic          busy;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model. m_owner is 0 when the target is free; otherwise it
    // holds the ID handed out and not yet completed.
    int m_sp = 0, m_si = 0, m_owner = 0, m_claim_id = 0;
    int m_clr_vld = 0, m_clr_idx = 0, m_cmpl_vld = 0, m_cmpl_idx = 0;
    int m_irq_reg = 0;

    task automatic step(input bit r, input int p, input int i, input int t,
                        input bit cl, input bit co, input int cid);
        exp_t e;
        bit   req;
        rst_i         = r;
        prio_i        = p[PW-1:0];
        idx_i         = i[IW-1:0];
        thold_i       = t[PW-1:0];
        claim_i       = cl;
        complete_i    = co;
        complete_id_i = cid[IW-1:0];
        // Expected outputs for this cycle.
`ifdef PLIC_TARGET_IRQ_REG_EN
        e.irq = (m_irq_reg != 0);
`else
        e.irq = (m_owner == 0) && (m_si != 0) && (m_sp > t);
`endif
        e.claim_id = m_claim_id[IW-1:0];
        e.clr_vld  = (m_clr_vld != 0);
        e.clr_idx  = m_clr_idx[IW-1:0];
        e.cmpl_vld = (m_cmpl_vld != 0);
        e.cmpl_idx = m_cmpl_idx[IW-1:0];
        e.busy     = (m_owner != 0);
        exp_q.push_back(e);
        @(posedge clk_i);
        // Model the effect of this cycle's inputs at the clock edge.
        if (r) begin
            m_sp = 0; m_si = 0; m_owner = 0; m_claim_id = 0;
            m_clr_vld = 0; m_clr_idx = 0; m_cmpl_vld = 0; m_cmpl_idx = 0;
            m_irq_reg = 0;
        end else begin
            req = (m_si != 0) && (m_sp > t);
            m_clr_vld  = 0;
            m_cmpl_vld = 0;
            if (m_owner != 0) begin
                if (cl) m_claim_id = 0;
                if (co && (cid == m_owner)) begin
                    m_cmpl_vld = 1;
                    m_cmpl_idx = cid;
                    m_owner    = 0;
                end
            end else if (cl) begin
                if (req) begin
                    m_claim_id = m_si;
                    m_clr_vld  = 1;
                    m_clr_idx  = m_si;
                    m_owner    = m_si;
                end else begin
                    m_claim_id = 0;
                end
            end
            m_irq_reg = (req && !cl && (m_owner == 0)) ? 1 : 0;
            m_sp = p;
            m_si = i;
        end
        #1;
    endtask

    // Monitor: compare every cycle that has a pushed expectation.
    always @(negedge clk_i) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (irq_o !== e.irq || claim_id_o !== e.claim_id ||
                clr_vld_o !== e.clr_vld || clr_idx_o !== e.clr_idx ||
                cmpl_vld_o !== e.cmpl_vld || cmpl_idx_o !== e.cmpl_idx ||
                busy_o !== e.busy) begin
                errors++;
                $display("FAIL outputs t=%0t got irq=%b cid=%0d clr=%b/%0d cmpl=%b/%0d busy=%b exp irq=%b cid=%0d clr=%b/%0d cmpl=%b/%0d busy=%b",
                         $time, irq_o, claim_id_o, clr_vld_o, clr_idx_o,
                         cmpl_vld_o, cmpl_idx_o, busy_o, e.irq, e.claim_id,
                         e.clr_vld, e.clr_idx, e.cmpl_vld, e.cmpl_idx, e.busy);
            end else if (e.clr_vld || e.cmpl_vld) begin
                $display("txn t=%0t clr=%b/%0d cmpl=%b/%0d claim_id=%0d busy=%b",
                         $time, clr_vld_o, clr_idx_o, cmpl_vld_o, cmpl_idx_o,
                         claim_id_o, busy_o);
            end
        end
    end

    initial begin
        int p, i, t, cid;
        bit r, cl, co;
        @(posedge clk_i);
        #1;
        // Reset held with a live winner; irq follows after release.
        step(1, 5, 3, 2, 0, 0, 0);
        step(1, 5, 3, 2, 0, 0, 0);
        step(0, 5, 3, 2, 0, 0, 0);
        step(0, 5, 3, 2, 0, 0, 0);
        // Threshold edge: equal does not interrupt, one lower does.
        step(0, 4, 7, 4, 0, 0, 0);
        step(0, 4, 7, 4, 0, 0, 0);
        step(0, 4, 7, 3, 0, 0, 0);
        // Claim then complete of ID 9.
        step(0, 6, 9, 0, 0, 0, 0);
        step(0, 6, 9, 0, 1, 0, 0);
        step(0, 6, 9, 0, 0, 0, 0);
        step(0, 6, 9, 0, 0, 1, 9);
        step(0, 6, 9, 0, 0, 0, 0);
        step(0, 6, 9, 0, 0, 0, 0);
        // Empty claims: ID 0, then priority 0.
        step(0, 6, 0, 0, 0, 0, 0);
        step(0, 6, 0, 0, 1, 0, 0);
        step(0, 0, 9, 0, 0, 0, 0);
        step(0, 0, 9, 0, 1, 0, 0);
        step(0, 0, 9, 0, 0, 0, 0);
        // Mismatch, second claim, simultaneous claim and complete.
        step(0, 6, 9, 0, 0, 0, 0);
        step(0, 6, 9, 0, 1, 0, 0);
        step(0, 6, 9, 0, 0, 1, 4);
        step(0, 6, 9, 0, 0, 0, 0);
        step(0, 6, 9, 0, 1, 0, 0);
        step(0, 6, 9, 0, 0, 0, 0);
        step(0, 6, 9, 0, 1, 1, 9);
        step(0, 6, 9, 0, 0, 0, 0);
        step(0, 6, 9, 0, 0, 0, 0);
        // Reset while CLAIMED, then claim/complete again.
        step(0, 6, 9, 0, 1, 0, 0);
        step(0, 6, 9, 0, 0, 0, 0);
        step(1, 6, 9, 0, 0, 1, 9);
        step(0, 6, 9, 0, 0, 0, 0);
        step(0, 6, 9, 0, 0, 0, 0);
        step(0, 6, 9, 0, 0, 0, 0);
        step(0, 6, 9, 0, 1, 0, 0);
        step(0, 6, 9, 0, 0, 1, 9);
        step(0, 6, 9, 0, 0, 0, 0);
        // Randomized traffic with sticky winners so claims often succeed.
        p = 0; i = 0; t = 0;
        for (int n = 0; n < 800; n++) begin
            r = ($urandom_range(63) == 0);
            if ($urandom_range(2) == 0) p = $urandom_range((1 << PW) - 1);
            if ($urandom_range(2) == 0) i = $urandom_range((1 << IW) - 1);
            if ($urandom_range(4) == 0) t = $urandom_range((1 << PW) - 1);
            cl  = ($urandom_range(3) == 0);
            co  = ($urandom_range(3) == 0);
            cid = ($urandom_range(1) == 0) ? m_owner : $urandom_range((1 << IW) - 1);
            step(r, p, i, t, cl, co, cid);
        end
        step(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
